// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refills and dcache refills/stores.
// Define ARB_TIMEOUT_EN to bound the memory wait by TIMEOUT cycles and flag aborts on err.
module mem_port_arbiter #(
    parameter int unsigned XLEN = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            busy,
    output logic            owner,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic            mem_req_next, mem_we_next, i_done_next, d_done_next;
    logic            busy_next, owner_next;
    logic [XLEN-1:0] mem_addr_next, mem_wdata_next, i_rdata_next, d_rdata_next;
    logic            grant_d;
    logic            expired;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt, cnt_next;
    logic          err_next;

    // Abort when this WAIT cycle would bring the count up to TIMEOUT.
    assign expired = (cnt == CW'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    // Under contention the grant goes to whoever did not own the port last.
    assign grant_d = d_req && (!i_req || !owner);

    always_comb begin
        state_next     = state;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        i_rdata_next   = i_rdata;
        d_rdata_next   = d_rdata;
        i_done_next    = 1'b0;
        d_done_next    = 1'b0;
        owner_next     = owner;
`ifdef ARB_TIMEOUT_EN
        cnt_next       = cnt;
        err_next       = err;
`endif
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_next   = WAIT;
                    mem_req_next = 1'b1;
                    owner_next   = grant_d;
`ifdef ARB_TIMEOUT_EN
                    cnt_next     = '0;
                    err_next     = 1'b0;
`endif
                    if (grant_d) begin
                        mem_we_next    = d_we;
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                    end else begin
                        mem_we_next    = 1'b0;
                        mem_addr_next  = i_addr;
                    end
                end
            end
            WAIT: begin
                if (mem_ready || expired) begin
                    state_next   = DONE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    i_done_next  = !owner;
                    d_done_next  = owner;
                    if (mem_ready && !owner) i_rdata_next = mem_rdata;
                    if (mem_ready && owner && !mem_we) d_rdata_next = mem_rdata;
`ifdef ARB_TIMEOUT_EN
                    err_next     = !mem_ready;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_next     = cnt + CW'(1);
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b1;
        end else begin
            state     <= state_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            i_rdata   <= i_rdata_next;
            d_rdata   <= d_rdata_next;
            i_done    <= i_done_next;
            d_done    <= d_done_next;
            busy      <= busy_next;
            owner     <= owner_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            err <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, round-robin, latency, reset and misuse cases.
// With ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT = 4 and the abort path is exercised.
module tb_mem_port_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req, d_req, d_we, mem_ready;
    logic [XLEN-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [XLEN-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic            i_done, d_done, mem_req, mem_we, busy, owner, err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN(XLEN)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .owner(owner), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        check("rst_done", 32'({i_done, d_done}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // icache read, memory answers in the third WAIT cycle
        i_req = 1'b1; i_addr = 32'h100;
        tick();
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_hold", 32'(mem_req), 32'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        check("t1_i_done", 32'(i_done), 32'd1);
        check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        check("t1_d_done", 32'(d_done), 32'd0);
        check("t1_mem_req_drop", 32'(mem_req), 32'd0);
        mem_ready = 1'b0; i_req = 1'b0;
        tick();
        check("t1_done_once", 32'(i_done), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_rdata_hold", i_rdata, 32'hDEADBEEF);

        // simultaneous requests after reset: icache, dcache store, icache
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t2_owner_rst", 32'(owner), 32'd1);
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        tick();
        check("t2_first_owner", 32'(owner), 32'd0);
        check("t2_first_addr", mem_addr, 32'h300);
        check("t2_first_we", 32'(mem_we), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick();
        check("t2_i_done", 32'(i_done), 32'd1);
        check("t2_d_done_idle", 32'(d_done), 32'd0);
        mem_ready = 1'b0; i_req = 1'b0;
        tick();
        check("t2_no_grant_done", 32'(mem_req), 32'd0);
        tick();
        check("t2_second_owner", 32'(owner), 32'd1);
        check("t2_second_we", 32'(mem_we), 32'd1);
        check("t2_second_addr", mem_addr, 32'h200);
        check("t2_second_wdata", mem_wdata, 32'h55);
        mem_ready = 1'b1; mem_rdata = 32'h99999999;
        tick();
        check("t2_d_done", 32'(d_done), 32'd1);
        check("t2_store_rdata", d_rdata, 32'h0);
        mem_ready = 1'b0; d_req = 1'b0;
        tick();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        tick();
        check("t2_third_owner", 32'(owner), 32'd0);
        check("t2_third_addr", mem_addr, 32'h300);
        mem_ready = 1'b1; mem_rdata = 32'h22222222;
        tick();
        check("t2_third_done", 32'(i_done), 32'd1);
        mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
        tick();

        // zero-wait memory, requester slow to drop req
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        check("t3_mem_req", 32'(mem_req), 32'd1);
        check("t3_owner", 32'(owner), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        check("t3_d_done", 32'(d_done), 32'd1);
        check("t3_d_rdata", d_rdata, 32'hCAFEF00D);
        check("t3_mem_req_drop", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        tick();
        check("t3_no_regrant", 32'(mem_req), 32'd0);
        check("t3_done_once", 32'(d_done), 32'd0);
        d_req = 1'b0;
        tick();
        check("t3_idle", 32'(mem_req), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // memory never answers: abort after 4 WAIT cycles
        i_req = 1'b1; i_addr = 32'h800;
        tick();
        check("t6_mem_req", 32'(mem_req), 32'd1);
        check("t6_err_grant", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_wait", 32'(mem_req), 32'd1);
        end
        tick();
        check("t6_mem_req_drop", 32'(mem_req), 32'd0);
        check("t6_i_done", 32'(i_done), 32'd1);
        check("t6_err", 32'(err), 32'd1);
        check("t6_rdata_keep", i_rdata, 32'h22222222);
        i_req = 1'b0;
        tick();
        check("t6_done_once", 32'(i_done), 32'd0);
`endif

        // reset in the middle of a dcache store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h77;
        tick();
        check("t4_mem_req", 32'(mem_req), 32'd1);
        check("t4_mem_we", 32'(mem_we), 32'd1);
        check("t4_err_clear", 32'(err), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_req = 1'b0;
        check("t4_mem_req_rst", 32'(mem_req), 32'd0);
        check("t4_d_done", 32'(d_done), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_owner", 32'(owner), 32'd1);
        tick();
        check("t4_no_done", 32'(d_done), 32'd0);

        // spurious mem_ready in IDLE, then req dropped and address changed mid-WAIT
        mem_ready = 1'b1;
        tick();
        check("t5_idle_req", 32'(mem_req), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_done", 32'({i_done, d_done}), 32'd0);
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        tick();
        check("t5_grant", 32'(mem_req), 32'd1);
        d_req = 1'b0; d_addr = 32'h7FC;
        tick();
        check("t5_hold", 32'(mem_req), 32'd1);
        check("t5_addr_frozen", mem_addr, 32'h700);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        check("t5_d_done", 32'(d_done), 32'd1);
        check("t5_d_rdata", d_rdata, 32'h12345678);
        tick();
        check("t5_done_once", 32'(d_done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_mem_req", 32'(mem_req), 32'd0);
        check("t5_rdata_hold", d_rdata, 32'h12345678);
        mem_ready = 1'b0;
        tick();
        check("t5_quiet", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
